axi_bridge_wb: RTL and testbench

- Second-generation AXI3 bridge between the icache/dcache request ports and the single AXI master port.
- Parametrised line length; read-type and write-type encodings are unchanged from the previous bridge.
- Adds a real multi-entry posted write buffer that decouples dcache writebacks from the AXI write channel.
- Adds read-after-write hazard protection, so reads no longer stall on every in-flight write.

---
 rtl/axi_bridge_pkg.sv | 53 +++++
 rtl/axi_wb_fifo.sv | 85 ++++++++
 rtl/axi_bridge_wb.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_bridge_wb.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the AXI3 / write-buffer bridge: AXI constant fields,
// transaction IDs, request-type decode and the write-buffer entry header.
package axi_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;
    localparam logic [3:0] ID_WRITE  = 4'd1;

    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
    } axi_len_size_t;

    // Line data is kept beside the header in the FIFO because its width
    // follows LINE_WORDS, which a package typedef cannot see.
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  wstrb;
    } wb_hdr_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_B
    } wr_state_t;

    // A line request becomes an INCR burst of whole words; anything else is a
    // single beat whose size is the type field itself.
    function automatic axi_len_size_t decode_type(input logic [2:0] req_type,
                                                  input int unsigned line_words);
        axi_len_size_t ls;
        if (req_type == TYPE_LINE) begin
            ls.len  = 8'(line_words - 1);
            ls.size = SIZE_WORD;
        end else begin
            ls.len  = 8'd0;
            ls.size = req_type;
        end
        return ls;
    endfunction

endpackage

// File: rtl/axi_wb_fifo.sv
// Posted write buffer: circular FIFO of line writes with a per-entry valid
// bit. With AXI_BRIDGE_WB_RAW_CHECK_EN defined it also returns, for two
// lookup line addresses, a vector of entries holding that line.
module axi_wb_fifo
    import axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int DEPTH      = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 push,
    input  wb_hdr_t                              push_hdr,
    input  logic [32*LINE_WORDS-1:0]             push_data,
    input  logic                                 pop,
`ifdef AXI_BRIDGE_WB_RAW_CHECK_EN
    input  logic [31:$clog2(LINE_WORDS*4)]       d_line,
    input  logic [31:$clog2(LINE_WORDS*4)]       i_line,
    output logic [DEPTH-1:0]                     d_match,
    output logic [DEPTH-1:0]                     i_match,
`endif
    output wb_hdr_t                              head_hdr,
    output logic [32*LINE_WORDS-1:0]             head_data,
    output logic                                 full,
    output logic                                 empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_hdr_t                    hdr_mem  [DEPTH];
    logic [32*LINE_WORDS-1:0]   data_mem [DEPTH];
    logic [DEPTH-1:0]           valid;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    // pointers, occupancy count and per-entry valid bits
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // entry storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clock) begin
        if (push) begin
            hdr_mem[wr_ptr]  <= push_hdr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_hdr  = hdr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

`ifdef AXI_BRIDGE_WB_RAW_CHECK_EN
    localparam int OFFSET_W = $clog2(LINE_WORDS * 4);

    // parallel line compare against every live entry, head included
    always_comb begin
        d_match = '0;
        i_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            d_match[k] = valid[k] && (hdr_mem[k].addr[31:OFFSET_W] == d_line);
            i_match[k] = valid[k] && (hdr_mem[k].addr[31:OFFSET_W] == i_line);
        end
    end
`endif

endmodule

// File: rtl/axi_bridge_wb.sv
// AXI3 bridge between icache/dcache ports and one AXI master, with a posted
// write buffer. Macro AXI_BRIDGE_WB_RAW_CHECK_EN: defined -> reads stall only
// on a line match against buffered writes; undefined -> reads stall whenever
// any write is buffered or in flight.
//
// Write engine states:
//   state   | meaning
//   WR_IDLE | no write on the bus, waiting for a buffered entry
//   WR_AW   | awvalid held with the head entry's address
//   WR_W    | streaming head entry beats, beat_cnt selects the word
//   WR_B    | bready held, head popped when the response arrives
module axi_bridge_wb
    import axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int WB_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        arvalid,
    input  logic                        arready,
    output logic [3:0]                  arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [1:0]                  arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    input  logic                        rvalid,
    output logic                        rready,
    input  logic [3:0]                  rid,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [3:0]                  awid,
    output logic [31:0]                 awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic [1:0]                  awlock,
    output logic [3:0]                  awcache,
    output logic [2:0]                  awprot,
    output logic                        wvalid,
    input  logic                        wready,
    output logic                        wlast,
    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic [3:0]                  wid,
    input  logic                        bvalid,
    output logic                        bready,
    input  logic [3:0]                  bid,
    input  logic [1:0]                  bresp,
    input  logic                        i_rd_req,
    input  logic [2:0]                  i_rd_type,
    input  logic [31:0]                 i_rd_addr,
    output logic                        i_rd_rdy,
    output logic                        i_ret_valid,
    output logic                        i_ret_last,
    output logic [31:0]                 i_ret_data,
    input  logic                        d_rd_req,
    input  logic [2:0]                  d_rd_type,
    input  logic [31:0]                 d_rd_addr,
    output logic                        d_rd_rdy,
    output logic                        d_ret_valid,
    output logic                        d_ret_last,
    output logic [31:0]                 d_ret_data,
    input  logic                        d_wr_req,
    input  logic [2:0]                  d_wr_type,
    input  logic [31:0]                 d_wr_addr,
    input  logic [3:0]                  d_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]    d_wr_data,
    output logic                        d_wr_rdy,
    output logic                        write_buffer_empty
);

    localparam int CNT_W = $clog2(LINE_WORDS);

    // response ID/status carry nothing the caches need
    logic unused_resp;
    assign unused_resp = ^{rresp, bid, bresp};

    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign awid    = ID_WRITE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NORMAL;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;
    assign wid     = ID_WRITE;
    assign rready  = 1'b1;

    assign d_ret_valid = rvalid && (rid == ID_DCACHE);
    assign d_ret_last  = rlast;
    assign d_ret_data  = rdata;
    assign i_ret_valid = rvalid && (rid != ID_DCACHE);
    assign i_ret_last  = rlast;
    assign i_ret_data  = rdata;

    wb_hdr_t                  push_hdr;
    wb_hdr_t                  head_hdr;
    logic [32*LINE_WORDS-1:0] head_data;
    logic                     wb_full;
    logic                     wb_empty;
    logic                     wb_push;
    logic                     wb_pop;
    axi_len_size_t            wr_ls;
    wr_state_t                wr_state;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         beat_next;

    assign wr_ls    = decode_type(d_wr_type, LINE_WORDS);
    assign push_hdr = '{addr: d_wr_addr, len: wr_ls.len, size: wr_ls.size, wstrb: d_wr_wstrb};
    assign d_wr_rdy = !wb_full;
    assign wb_push  = d_wr_req && !wb_full;
    assign wb_pop   = (wr_state == WR_B) && bvalid;
    assign write_buffer_empty = wb_empty;

    logic d_blocked;
    logic i_blocked;

`ifdef AXI_BRIDGE_WB_RAW_CHECK_EN
    localparam int OFFSET_W = $clog2(LINE_WORDS * 4);

    logic [WB_DEPTH-1:0] d_match;
    logic [WB_DEPTH-1:0] i_match;

    axi_wb_fifo #(.LINE_WORDS(LINE_WORDS), .DEPTH(WB_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wb_push),
        .push_hdr  (push_hdr),
        .push_data (d_wr_data),
        .pop       (wb_pop),
        .d_line    (d_rd_addr[31:OFFSET_W]),
        .i_line    (i_rd_addr[31:OFFSET_W]),
        .d_match   (d_match),
        .i_match   (i_match),
        .head_hdr  (head_hdr),
        .head_data (head_data),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    // an entry entering the buffer this cycle is not in the match vector yet
    assign d_blocked = (|d_match) || (wb_push && (d_wr_addr[31:OFFSET_W] == d_rd_addr[31:OFFSET_W]));
    assign i_blocked = (|i_match) || (wb_push && (d_wr_addr[31:OFFSET_W] == i_rd_addr[31:OFFSET_W]));
`else
    axi_wb_fifo #(.LINE_WORDS(LINE_WORDS), .DEPTH(WB_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wb_push),
        .push_hdr  (push_hdr),
        .push_data (d_wr_data),
        .pop       (wb_pop),
        .head_hdr  (head_hdr),
        .head_data (head_data),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    assign d_blocked = !wb_empty;
    assign i_blocked = !wb_empty;
`endif

    // a blocked d request still wins arbitration, which holds i behind it
    logic          ar_can_load;
    axi_len_size_t d_ls;
    axi_len_size_t i_ls;

    assign ar_can_load = !arvalid || arready;
    assign d_rd_rdy    = ar_can_load && d_rd_req && !d_blocked;
    assign i_rd_rdy    = ar_can_load && i_rd_req && !d_rd_req && !i_blocked;
    assign d_ls        = decode_type(d_rd_type, LINE_WORDS);
    assign i_ls        = decode_type(i_rd_type, LINE_WORDS);

    // single AR slot, reloaded in the handshake cycle so bursts go back to back
    always_ff @(posedge clock) begin
        if (reset) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
        end else if (d_rd_rdy) begin
            arvalid <= 1'b1;
            arid    <= ID_DCACHE;
            araddr  <= d_rd_addr;
            arlen   <= d_ls.len;
            arsize  <= d_ls.size;
        end else if (i_rd_rdy) begin
            arvalid <= 1'b1;
            arid    <= ID_ICACHE;
            araddr  <= i_rd_addr;
            arlen   <= i_ls.len;
            arsize  <= i_ls.size;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    assign beat_next = beat_cnt + CNT_W'(1);
    assign wdata     = head_data[{beat_cnt, 5'b00000} +: 32];
    assign wstrb     = head_hdr.wstrb;

    // write engine: drains the buffer head through AW, W and B in order
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            awvalid  <= 1'b0;
            awaddr   <= '0;
            awlen    <= '0;
            awsize   <= '0;
            wvalid   <= 1'b0;
            wlast    <= 1'b0;
            bready   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (!wb_empty) begin
                        awvalid  <= 1'b1;
                        awaddr   <= head_hdr.addr;
                        awlen    <= head_hdr.len;
                        awsize   <= head_hdr.size;
                        wr_state <= WR_AW;
                    end
                end
                WR_AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        wvalid   <= 1'b1;
                        beat_cnt <= '0;
                        wlast    <= (head_hdr.len == 8'd0);
                        wr_state <= WR_W;
                    end
                end
                WR_W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid   <= 1'b0;
                            wlast    <= 1'b0;
                            bready   <= 1'b1;
                            wr_state <= WR_B;
                        end else begin
                            beat_cnt <= beat_next;
                            wlast    <= (8'(beat_next) == head_hdr.len);
                        end
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready   <= 1'b0;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_bridge_wb.sv
// Directed bench for axi_bridge_wb: table of read requests/returns plus
// hand-written write-buffer, burst, hazard and reset sequences.
module tb_axi_bridge_wb;

    localparam int LINE_WORDS = 4;
    localparam int WB_DEPTH   = 4;

`ifdef AXI_BRIDGE_WB_RAW_CHECK_EN
    localparam bit RAW_EN = 1'b1;
`else
    localparam bit RAW_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic arvalid, arready;
    logic [3:0] arid;
    logic [31:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst, arlock;
    logic [3:0] arcache;
    logic [2:0] arprot;
    logic rvalid, rready, rlast;
    logic [3:0] rid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic awvalid, awready;
    logic [3:0] awid;
    logic [31:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst, awlock;
    logic [3:0] awcache;
    logic [2:0] awprot;
    logic wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0] wstrb, wid;
    logic bvalid, bready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
    logic [2:0] i_rd_type;
    logic [31:0] i_rd_addr, i_ret_data;
    logic d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
    logic [2:0] d_rd_type;
    logic [31:0] d_rd_addr, d_ret_data;
    logic d_wr_req, d_wr_rdy;
    logic [2:0] d_wr_type;
    logic [31:0] d_wr_addr;
    logic [3:0] d_wr_wstrb;
    logic [32*LINE_WORDS-1:0] d_wr_data;
    logic write_buffer_empty;

    axi_bridge_wb #(.LINE_WORDS(LINE_WORDS), .WB_DEPTH(WB_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .wstrb(wstrb), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .write_buffer_empty(write_buffer_empty)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        d_req;
        logic        i_req;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [3:0]  ret_id;
        logic        ret_last;
        logic [3:0]  exp_arid;
        logic [7:0]  exp_arlen;
        logic [2:0]  exp_arsize;
        logic        exp_d_ret;
        logic        exp_i_ret;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] make_line(input int k);
        logic [127:0] v;
        for (int w = 0; w < 4; w++) v[32*w +: 32] = 32'hC000_0000 + 32'(k * 256 + w);
        return v;
    endfunction

    // Completes one buffered write on AW/W/B, checking every beat.
    task automatic drain_one(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                             input logic [2:0] exp_size, input logic [3:0] exp_strb,
                             input logic [127:0] exp_data, input bit toggle, input bit chk_blk);
        int guard;
        guard = 0;
        while (!awvalid && guard < 20) begin
            step();
            guard++;
        end
        check("awvalid", awvalid, 1);
        check("awaddr", awaddr, exp_addr);
        check("awlen", awlen, exp_len);
        check("awsize", awsize, exp_size);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check("aw_drop", awvalid, 0);
        for (int b = 0; b <= int'(exp_len); b++) begin
            if (toggle) begin
                wready = 1'b0;
                step();
                check("w_hold_valid", wvalid, 1);
                check("w_hold_data", wdata, exp_data[32*b +: 32]);
            end
            check("wvalid", wvalid, 1);
            check("wdata", wdata, exp_data[32*b +: 32]);
            check("wstrb", wstrb, exp_strb);
            check("wlast", wlast, 32'(b == int'(exp_len)));
            if (chk_blk) check("rd_blocked", d_rd_rdy, 0);
            wready = 1'b1;
            step();
            wready = 1'b0;
        end
        check("bready", bready, 1);
        check("w_done", wvalid, 0);
        if (chk_blk) check("rd_blocked_b", d_rd_rdy, 0);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("b_done", bready, 0);
    endtask

    initial begin
        logic [127:0] abcd;

        vecs[0] = '{1'b1, 1'b0, 3'b100, 32'h0000_1000, 4'd1, 1'b1, 4'd1, 8'd3, 3'd2, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 3'b100, 32'h0000_2000, 4'd0, 1'b0, 4'd0, 8'd3, 3'd2, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 3'b000, 32'h0000_1234, 4'd1, 1'b1, 4'd1, 8'd0, 3'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 3'b010, 32'h0000_2004, 4'd0, 1'b1, 4'd0, 8'd0, 3'd2, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 3'b001, 32'h0000_3002, 4'd5, 1'b0, 4'd1, 8'd0, 3'd1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 3'b011, 32'h0000_8008, 4'd1, 1'b0, 4'd1, 8'd0, 3'd3, 1'b1, 1'b0};

        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;

        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();

        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_wb_empty", write_buffer_empty, 1);
        check("rst_wr_rdy", d_wr_rdy, 1);
        check("rst_rready", rready, 1);
        check("rst_araddr", araddr, 0);
        check("const_awid", awid, 1);
        check("const_wid", wid, 1);
        check("const_arburst", arburst, 1);

        // table: request decode, arbitration and return routing
        arready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            d_rd_req = vecs[v].d_req; i_rd_req = vecs[v].i_req;
            d_rd_type = vecs[v].typ;  i_rd_type = vecs[v].typ;
            d_rd_addr = vecs[v].addr; i_rd_addr = vecs[v].addr;
            step();
            d_rd_req = 1'b0; i_rd_req = 1'b0;
            check("tbl_arvalid", arvalid, 1);
            check("tbl_arid", arid, vecs[v].exp_arid);
            check("tbl_araddr", araddr, vecs[v].addr);
            check("tbl_arlen", arlen, vecs[v].exp_arlen);
            check("tbl_arsize", arsize, vecs[v].exp_arsize);
            rvalid = 1'b1; rid = vecs[v].ret_id; rlast = vecs[v].ret_last;
            rdata = 32'h5A00_0000 + 32'(v);
            #1;
            check("tbl_d_ret", d_ret_valid, vecs[v].exp_d_ret);
            check("tbl_i_ret", i_ret_valid, vecs[v].exp_i_ret);
            if (vecs[v].exp_d_ret) begin
                check("tbl_d_data", d_ret_data, 32'h5A00_0000 + 32'(v));
                check("tbl_d_last", d_ret_last, vecs[v].ret_last);
            end else begin
                check("tbl_i_data", i_ret_data, 32'h5A00_0000 + 32'(v));
                check("tbl_i_last", i_ret_last, vecs[v].ret_last);
            end
            rvalid = 1'b0;
            step();
            check("tbl_ar_drop", arvalid, 0);
        end

        // d and i together: d first, i on the next arready without a bubble
        arready = 1'b0;
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h1000;
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h2000;
        #1;
        check("pri_d_rdy", d_rd_rdy, 1);
        check("pri_i_rdy", i_rd_rdy, 0);
        step();
        d_rd_req = 0;
        check("pri_arid_d", arid, 1);
        check("pri_araddr_d", araddr, 32'h1000);
        check("pri_arlen", arlen, 3);
        check("pri_arsize", arsize, 2);
        #1;
        check("pri_i_wait", i_rd_rdy, 0);
        arready = 1'b1;
        #1;
        check("pri_i_rdy2", i_rd_rdy, 1);
        step();
        i_rd_req = 0;
        check("pri_arvalid_i", arvalid, 1);
        check("pri_arid_i", arid, 0);
        check("pri_araddr_i", araddr, 32'h2000);
        step();
        check("pri_ar_idle", arvalid, 0);
        for (int b = 0; b < 4; b++) begin
            rvalid = 1; rid = 4'd1; rdata = 32'hD000_0000 + 32'(b); rlast = (b == 3);
            #1;
            check("r_d_valid", d_ret_valid, 1);
            check("r_i_quiet", i_ret_valid, 0);
            check("r_d_data", d_ret_data, 32'hD000_0000 + 32'(b));
            check("r_d_last", d_ret_last, 32'(b == 3));
            step();
        end
        rvalid = 0; rlast = 0;

        // fill the buffer with awready held low
        awready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h5000 + 32'(k * 16);
            d_wr_wstrb = 4'hF; d_wr_data = make_line(k);
            #1;
            check("fill_rdy", d_wr_rdy, 1);
            step();
        end
        d_wr_addr = 32'h5040; d_wr_data = make_line(4);
        #1;
        check("fill_full", d_wr_rdy, 0);
        check("fill_not_empty", write_buffer_empty, 0);
        drain_one(32'h5000, 8'd3, 3'd2, 4'hF, make_line(0), 1'b0, 1'b0);
        check("pop_rdy", d_wr_rdy, 1);
        step();
        d_wr_req = 0;
        check("refull", d_wr_rdy, 0);
        for (int k = 1; k < 5; k++)
            drain_one(32'h5000 + 32'(k * 16), 8'd3, 3'd2, 4'hF, make_line(k), 1'b0, 1'b0);
        check("drained_empty", write_buffer_empty, 1);

        // read-after-write hazard around a buffered line write to 0x3000
        abcd = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        arready = 1'b1;
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h3000; d_wr_wstrb = 4'hF; d_wr_data = abcd;
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h3004;
        #1;
        check("raw_push_same_cycle", d_rd_rdy, RAW_EN ? 32'd0 : 32'd1);
        step();
        d_wr_req = 0;
        d_rd_addr = 32'h3008;
        #1;
        check("raw_same_line", d_rd_rdy, 0);
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h6000;
        #1;
        check("raw_i_behind_d", i_rd_rdy, 0);
        step();
        check("raw_same_line2", d_rd_rdy, 0);
        d_rd_addr = 32'h4000;
        #1;
        check("raw_other_line", d_rd_rdy, RAW_EN ? 32'd1 : 32'd0);
        d_rd_req = 0;
        #1;
        check("raw_i_alone", i_rd_rdy, RAW_EN ? 32'd1 : 32'd0);
        i_rd_req = 0;
        d_rd_req = 1; d_rd_addr = 32'h3008;
        drain_one(32'h3000, 8'd3, 3'd2, 4'hF, abcd, 1'b1, 1'b1);
        check("raw_released", d_rd_rdy, 1);
        step();
        d_rd_req = 0;
        check("raw_ar_addr", araddr, 32'h3008);
        check("raw_ar_valid", arvalid, 1);
        step();

        // single byte write
        d_wr_req = 1; d_wr_type = 3'b000; d_wr_addr = 32'h3001; d_wr_wstrb = 4'b0010;
        d_wr_data = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_5500};
        step();
        d_wr_req = 0;
        drain_one(32'h3001, 8'd0, 3'd0, 4'b0010, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_5500},
                  1'b0, 1'b0);
        check("byte_empty", write_buffer_empty, 1);

        // reset in the middle of a write burst
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h7000; d_wr_wstrb = 4'hF; d_wr_data = make_line(7);
        step();
        d_wr_req = 0;
        step();
        awready = 1; step(); awready = 0;
        wready = 1; step(); wready = 0;
        check("mid_wvalid", wvalid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_wvalid", wvalid, 0);
        check("mid_rst_awvalid", awvalid, 0);
        check("mid_rst_bready", bready, 0);
        check("mid_rst_empty", write_buffer_empty, 1);
        check("mid_rst_wr_rdy", d_wr_rdy, 1);
        step();
        check("mid_rst_stays_idle", awvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
